// File: rtl/c_packet_lock_ctrl_pkg.sv
// Shared types and constants for the wormhole packet lock controller.
package c_packet_lock_ctrl_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    localparam int DefaultMaxPktLen = 16;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clogb(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/c_packet_lock_ctrl_if.sv
// Flit handshake and arbiter request/grant bundle around the packet lock controller.
interface c_packet_lock_ctrl_if #(
    parameter int num_ports = 32
);

    logic [0:num_ports-1] flit_valid_ip;
    logic [0:num_ports-1] flit_head_ip;
    logic [0:num_ports-1] flit_tail_ip;
    logic                 ready;
    logic [0:num_ports-1] arb_req;
    logic [0:num_ports-1] arb_gnt;
    logic                 arb_update;
    logic [0:num_ports-1] flit_sel_op;
    logic                 flit_xfer;

    modport slave (
        input  flit_valid_ip,
        input  flit_head_ip,
        input  flit_tail_ip,
        input  ready,
        input  arb_gnt,
        output arb_req,
        output arb_update,
        output flit_sel_op,
        output flit_xfer
    );

    modport master (
        output flit_valid_ip,
        output flit_head_ip,
        output flit_tail_ip,
        output ready,
        output arb_gnt,
        input  arb_req,
        input  arb_update,
        input  flit_sel_op,
        input  flit_xfer
    );

endinterface

// File: rtl/c_pkt_len_counter.sv
// Saturating flit counter for the packet currently holding the lock.
module c_pkt_len_counter
    import c_packet_lock_ctrl_pkg::*;
#(
    parameter int max_pkt_len = DefaultMaxPktLen,
    parameter int len_width   = clogb(max_pkt_len + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic clear,
    input  logic inc,
    output logic at_max
);

    logic [len_width-1:0] count_q;
    logic [len_width-1:0] count_d;

    assign at_max = (count_q == len_width'(max_pkt_len));

    // Clear wins over increment so a tail flit always leaves the counter at zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && !at_max) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (active) begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/c_packet_lock_ctrl.sv
// Packet-level allocator: arbitrates head flits, then locks the winner until its tail.
module c_packet_lock_ctrl
    import c_packet_lock_ctrl_pkg::*;
#(
    parameter int num_ports   = 32,
    parameter int max_pkt_len = DefaultMaxPktLen
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 active,
    c_packet_lock_ctrl_if.slave  bus,
    output logic [0:num_ports-1] owner,
    output logic                 locked,
    output logic                 err_len,
    output logic                 err_proto
);

    localparam int len_width = clogb(max_pkt_len + 1);

    lock_state_e          state_q;
    lock_state_e          state_d;
    logic [0:num_ports-1] owner_q;
    logic [0:num_ports-1] owner_d;
    logic                 errLen_q;
    logic                 errLen_d;
    logic                 errProto_q;
    logic                 errProto_d;

    logic [0:num_ports-1] reqRaw;
    logic [0:num_ports-1] selRaw;
    logic                 updateRaw;
    logic                 lenClear;
    logic                 lenInc;
    logic                 lenAtMax;
    logic                 stepEnable;

    assign stepEnable = active && !reset;

    c_pkt_len_counter #(
        .max_pkt_len (max_pkt_len),
        .len_width   (len_width)
    ) u_len_counter (
        .clk    (clk),
        .reset  (reset),
        .active (active),
        .clear  (lenClear),
        .inc    (lenInc),
        .at_max (lenAtMax)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        errLen_d   = errLen_q;
        errProto_d = errProto_q;
        reqRaw     = '0;
        selRaw     = '0;
        updateRaw  = 1'b0;
        lenClear   = 1'b0;
        lenInc     = 1'b0;

        case (state_q)
            IDLE: begin
                reqRaw = bus.ready ? (bus.flit_valid_ip & bus.flit_head_ip) : '0;
                if (|bus.arb_gnt) begin
                    selRaw    = bus.arb_gnt;
                    updateRaw = 1'b1;
                    if (|(bus.arb_gnt & bus.flit_tail_ip)) begin
                        lenClear = 1'b1;
                    end else begin
                        state_d = LOCKED;
                        owner_d = bus.arb_gnt;
                        lenInc  = 1'b1;
                    end
                end
            end
            LOCKED: begin
                selRaw = bus.ready ? (owner_q & bus.flit_valid_ip) : '0;
                if (|selRaw) begin
                    lenInc = 1'b1;
                    if (|(owner_q & bus.flit_head_ip)) begin
                        errProto_d = 1'b1;
                    end
                    // A tail unlocks now; the next head can only win on the following cycle.
                    if (|(owner_q & bus.flit_tail_ip)) begin
                        state_d  = IDLE;
                        owner_d  = '0;
                        lenClear = 1'b1;
                    end else if (lenAtMax) begin
                        errLen_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            errLen_q   <= 1'b0;
            errProto_q <= 1'b0;
        end else if (active) begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            errLen_q   <= errLen_d;
            errProto_q <= errProto_d;
        end
    end

    assign bus.arb_req     = reqRaw;
    assign bus.flit_sel_op = stepEnable ? selRaw : '0;
    assign bus.flit_xfer   = stepEnable && (|selRaw);
    assign bus.arb_update  = stepEnable && updateRaw;

    assign owner     = owner_q;
    assign locked    = (state_q == LOCKED);
    assign err_len   = errLen_q;
    assign err_proto = errProto_q;

endmodule
